// File: rtl/jt12_i2s_tx.sv
// Stereo I2S transmitter fed by the channel accumulator through a one-deep holding buffer.
// Define JT12_I2S_LJ_EN for left-justified framing (load on bit 0, lrclk=1 marks the left slot).
module jt12_i2s_tx #(
    parameter int WIDTH    = 12,
    parameter int SLOTW    = 16,
    parameter int BCLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             bclk,
    output logic             lrclk,
    output logic             sdata,
    output logic             overrun,
    output logic             underrun,
    input  logic             clr_flags
);

    localparam int FRAMEW = 2 * SLOTW;
    localparam int BITW   = $clog2(FRAMEW);
    localparam int DIVW   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int PADW   = SLOTW - WIDTH;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(BCLK_DIV - 1);
    localparam logic [BITW-1:0] BIT_LAST = BITW'(FRAMEW - 1);
    localparam logic [BITW-1:0] BIT_SLOT = BITW'(SLOTW);

`ifdef JT12_I2S_LJ_EN
    localparam logic            LJ_MODE  = 1'b1;
    localparam logic [BITW-1:0] LOAD_BIT = '0;
`else
    localparam logic            LJ_MODE  = 1'b0;
    localparam logic [BITW-1:0] LOAD_BIT = BITW'(1);
`endif

    // Each sample sits left-justified in its slot with zero padding below it.
    function automatic logic [FRAMEW-1:0] pack_frame(input logic [WIDTH-1:0] l,
                                                     input logic [WIDTH-1:0] r);
        logic [SLOTW-1:0] l_pad;
        logic [SLOTW-1:0] r_pad;
        l_pad = SLOTW'(l) << PADW;
        r_pad = SLOTW'(r) << PADW;
        return {l_pad, r_pad};
    endfunction

    logic [0:0]        state_q, state_d;
    logic [DIVW-1:0]   div_q, div_d;
    logic [BITW-1:0]   bit_q, bit_d;
    logic              bclk_q, bclk_d;
    logic              lrclk_q, lrclk_d;
    logic              sdata_q, sdata_d;
    logic [FRAMEW-1:0] shift_q, shift_d;
    logic [WIDTH-1:0]  hold_l_q, hold_l_d;
    logic [WIDTH-1:0]  hold_r_q, hold_r_d;
    logic              pend_q, pend_d;
    logic              ovr_q, ovr_d;
    logic              und_q, und_d;

    logic              div_wrap;
    logic              fall_edge;
    logic              load_pt;
    logic [BITW-1:0]   bit_inc;
    logic [FRAMEW-1:0] frame_word;
    logic              ovr_evt;
    logic              und_evt;

    assign div_wrap   = (div_q == DIV_LAST);
    assign fall_edge  = (state_q == ST_RUN) && div_wrap && bclk_q;
    assign bit_inc    = (bit_q == BIT_LAST) ? '0 : bit_q + BITW'(1);
    assign load_pt    = fall_edge && (bit_inc == LOAD_BIT);
    assign frame_word = pack_frame(hold_l_q, hold_r_q);

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        bclk_d   = bclk_q;
        lrclk_d  = lrclk_q;
        sdata_d  = sdata_q;
        shift_d  = shift_q;
        hold_l_d = hold_l_q;
        hold_r_d = hold_r_q;
        pend_d   = pend_q;
        ovr_d    = ovr_q;
        und_d    = und_q;
        ovr_evt  = 1'b0;
        und_evt  = 1'b0;

        if (clk_en) begin
            // A strobe on the load tick refills the buffer after the frame took the old word.
            if (sample_valid) begin
                hold_l_d = left;
                hold_r_d = right;
                pend_d   = 1'b1;
            end else if (load_pt) begin
                pend_d = 1'b0;
            end
            ovr_evt = sample_valid && pend_q && !load_pt;
            und_evt = load_pt && !pend_q;

            if (state_q == ST_IDLE) begin
                if (sample_valid) begin
                    state_d = ST_RUN;
                    div_d   = '0;
                    bit_d   = '0;
                    bclk_d  = 1'b0;
                    if (LJ_MODE) begin
                        shift_d = pack_frame(left, right);
                        sdata_d = left[WIDTH-1];
                        lrclk_d = 1'b1;
                        pend_d  = 1'b0;
                    end
                end
            end else begin
                div_d = div_wrap ? '0 : div_q + DIVW'(1);
                if (div_wrap) begin
                    bclk_d = ~bclk_q;
                end
                if (fall_edge) begin
                    bit_d   = bit_inc;
                    lrclk_d = LJ_MODE ? (bit_inc < BIT_SLOT) : (bit_inc >= BIT_SLOT);
                    if (load_pt) begin
                        shift_d = frame_word;
                        sdata_d = frame_word[FRAMEW-1];
                    end else begin
                        shift_d = shift_q << 1;
                        sdata_d = shift_q[FRAMEW-2];
                    end
                end
            end

            ovr_d = (ovr_q & ~clr_flags) | ovr_evt;
            und_d = (und_q & ~clr_flags) | und_evt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            bclk_q   <= 1'b0;
            lrclk_q  <= 1'b0;
            sdata_q  <= 1'b0;
            shift_q  <= '0;
            hold_l_q <= '0;
            hold_r_q <= '0;
            pend_q   <= 1'b0;
            ovr_q    <= 1'b0;
            und_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            bclk_q   <= bclk_d;
            lrclk_q  <= lrclk_d;
            sdata_q  <= sdata_d;
            shift_q  <= shift_d;
            hold_l_q <= hold_l_d;
            hold_r_q <= hold_r_d;
            pend_q   <= pend_d;
            ovr_q    <= ovr_d;
            und_q    <= und_d;
        end
    end

    assign sample_ready = ~pend_q;
    assign bclk         = bclk_q;
    assign lrclk        = lrclk_q;
    assign sdata        = sdata_q;
    assign overrun      = ovr_q;
    assign underrun     = und_q;

endmodule

// File: tb/tb_jt12_i2s_tx.sv
// Self-checking bench for jt12_i2s_tx: tick-position reference model plus literal frame checks.
module tb_jt12_i2s_tx;

    localparam int W       = 12;
    localparam int S       = 16;
    localparam int D       = 4;
    localparam int FW      = 2 * S;
    localparam int FRAME   = 4 * S * D;
    localparam int LOADPOS = 2 * D;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clk_en = 1'b0;
    logic         sample_valid = 1'b0;
    logic         clr_flags = 1'b0;
    logic [W-1:0] left = '0;
    logic [W-1:0] right = '0;
    logic         sample_ready, bclk, lrclk, sdata, overrun, underrun;

    jt12_i2s_tx #(.WIDTH(W), .SLOTW(S), .BCLK_DIV(D)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .left(left), .right(right), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
        .overrun(overrun), .underrun(underrun), .clr_flags(clr_flags)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    bit half   = 1'b0;

    // Model state: n is the clk_en tick position inside the frame, counted from RUN entry.
    typedef struct packed {
        logic          run;
        int            n;
        logic [2*W-1:0] hold;
        logic          pend;
        logic [FW-1:0] cur;
        logic          loaded;
        logic          ov;
        logic          un;
    } model_t;

    model_t m = '0;

    function automatic logic [FW-1:0] padw(input logic [W-1:0] l, input logic [W-1:0] r);
        return {l, {(S-W){1'b0}}, r, {(S-W){1'b0}}};
    endfunction

    function automatic model_t step(input model_t mi, input logic sv, input logic [W-1:0] l,
                                    input logic [W-1:0] r, input logic clr);
        model_t q;
        int     w, bc;
        logic   fall, ld, eo, eu;
        q  = mi;
        eo = 1'b0;
        eu = 1'b0;
        if (!mi.run) begin
            if (sv) begin
                q.run  = 1'b1;
                q.n    = 0;
                q.hold = {l, r};
                q.pend = 1'b1;
            end
        end else begin
            q.n  = (mi.n + 1) % FRAME;
            w    = q.n / D;
            bc   = (w / 2) % FW;
            fall = (q.n % D == 0) && (w % 2 == 0);
            ld   = fall && (bc == 1);
            if (ld) begin
                q.cur    = padw(mi.hold[2*W-1:W], mi.hold[W-1:0]);
                q.loaded = 1'b1;
                eu       = !mi.pend;
            end
            if (sv) begin
                eo     = mi.pend && !ld;
                q.hold = {l, r};
                q.pend = 1'b1;
            end else if (ld) begin
                q.pend = 1'b0;
            end
        end
        q.ov = (mi.ov && !clr) || eo;
        q.un = (mi.un && !clr) || eu;
        return q;
    endfunction

    // {bclk, lrclk, sdata, sample_ready, overrun, underrun}
    function automatic logic [5:0] exp_out(input model_t mi);
        int            w, bc;
        logic          b, lr, sd;
        logic [FW-1:0] tmp;
        b  = 1'b0;
        lr = 1'b0;
        sd = 1'b0;
        if (mi.run) begin
            w  = mi.n / D;
            bc = (w / 2) % FW;
            b  = (w % 2) == 1;
            lr = bc >= S;
            tmp = mi.cur >> ((FW - bc) % FW);
            sd = mi.loaded ? tmp[0] : 1'b0;
        end
        return {b, lr, sd, !mi.pend, mi.ov, mi.un};
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) m = '0;
        else if (clk_en) m = step(m, sample_valid, left, right, clr_flags);
    end

    initial forever begin
        logic [5:0] act, expv;
        @(negedge clk);
        if (cmp_en) begin
            act  = {bclk, lrclk, sdata, sample_ready, overrun, underrun};
            expv = exp_out(m);
            checks++;
            if (act !== expv) begin
                errors++;
                $display("FAIL cycle_compare t=%0t got %b expected %b (bclk,lrclk,sdata,ready,ovr,und)",
                         $time, act, expv);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        if (half) begin
            clk_en = 1'b0;
            cyc();
        end
        clk_en = 1'b1;
        cyc();
    endtask

    task automatic wait_pos(input int p);
        int g;
        g = 0;
        while (!(m.run && m.n == p) && g < 4 * FRAME) begin
            tick();
            g++;
        end
        if (!(m.run && m.n == p)) begin
            checks++;
            errors++;
            $display("FAIL wait_pos timeout: pos %0d not reached", p);
        end
    endtask

    task automatic strobe(input logic [W-1:0] l, input logic [W-1:0] r, input logic clr);
        left = l;
        right = r;
        sample_valid = 1'b1;
        clr_flags = clr;
        tick();
        sample_valid = 1'b0;
        clr_flags = 1'b0;
    endtask

    // Samples one bit per bclk period, starting at the load point (bit_cnt 1) through bit_cnt 0.
    task automatic collect(input string name, output logic [FW-1:0] bits, output logic [FW-1:0] lr);
        wait_pos(LOADPOS);
        for (int k = 0; k < FW; k++) begin
            if (k > 0) repeat (2 * D) tick();
            bits = {bits[FW-2:0], sdata};
            lr   = {lr[FW-2:0], lrclk};
        end
        $display("frame %s: sdata 0x%08h lrclk 0x%08h", name, bits, lr);
    endtask

    task automatic measure(output int cyc_n);
        int g, stp;
        stp = half ? 2 : 1;
        g = 0;
        cyc_n = 0;
        while (bclk !== 1'b0 && g < 64) begin tick(); g++; end
        while (bclk !== 1'b1 && g < 64) begin tick(); g++; end
        while (bclk !== 1'b0 && g < 64) begin tick(); g++; cyc_n += stp; end
        while (bclk !== 1'b1 && g < 64) begin tick(); g++; cyc_n += stp; end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FW-1:0] bits, lr;
        logic [W-1:0]  al, ar, bl, br;
        int            per;

        cyc();
        cmp_en = 1'b1;
        repeat (2) cyc();
        chk("reset_outputs", 32'({bclk, lrclk, sdata, sample_ready, overrun, underrun}), 32'h04);
        rst_n = 1'b1;
        repeat (5) tick();
        chk("idle_quiet", 32'({bclk, lrclk, sdata}), 32'h0);

        // First sample: 0x7FF / 0x800
        strobe(12'h7FF, 12'h800, 1'b0);
        chk("ready_after_accept", 32'(sample_ready), 32'h0);
        collect("first", bits, lr);
        chk("first_frame", bits, 32'h7FF08000);
        chk("first_lrclk", lr, 32'h0001FFFE);
        chk("model_pin_first", m.cur, 32'h7FF08000);
        chk("ready_after_load", 32'(sample_ready), 32'h1);

        // Eight frames, each fed once before its load point
        for (int f = 0; f < 8; f++) begin
            wait_pos(100);
            strobe(W'($urandom), W'($urandom), f == 0);
        end
        wait_pos(20);
        chk("steady_flags", 32'({overrun, underrun}), 32'h0);

        // Two samples in one frame
        strobe(12'h123, 12'h456, 1'b0);
        wait_pos(60);
        strobe(12'h321, 12'h654, 1'b0);
        chk("overrun_set", 32'(overrun), 32'h1);
        collect("overrun", bits, lr);
        chk("overrun_frame", bits, 32'h32106540);
        chk("model_pin_overrun", m.cur, 32'h32106540);

        // Starved frame repeats the last sample
        wait_pos(100);
        strobe(12'h0AA, 12'h055, 1'b1);
        chk("overrun_cleared", 32'(overrun), 32'h0);
        collect("fresh", bits, lr);
        chk("fresh_frame", bits, 32'h0AA00550);
        chk("no_underrun_yet", 32'(underrun), 32'h0);
        collect("repeat", bits, lr);
        chk("repeat_frame", bits, 32'h0AA00550);
        chk("underrun_set", 32'(underrun), 32'h1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("underrun_cleared", 32'(underrun), 32'h0);

        // Strobe exactly on the load tick
        al = W'($urandom); ar = W'($urandom);
        bl = W'($urandom); br = W'($urandom);
        wait_pos(100);
        strobe(al, ar, 1'b1);
        wait_pos(LOADPOS - 1);
        left = bl; right = br; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        chk("load_tick_ready", 32'(sample_ready), 32'h0);
        chk("load_tick_overrun", 32'(overrun), 32'h0);
        chk("load_tick_msb", 32'(sdata), 32'(al[W-1]));
        collect("old_on_load", bits, lr);
        chk("old_sample_frame", bits, padw(al, ar));
        collect("new_after_load", bits, lr);
        chk("new_sample_frame", bits, padw(bl, br));
        chk("load_tick_flags", 32'({overrun, underrun}), 32'h0);

        // bclk period with full-rate and half-rate clock enable
        measure(per);
        chk("bclk_period_full", 32'(per), 32'(2 * D));
        half = 1'b1;
        measure(per);
        chk("bclk_period_half", 32'(per), 32'(4 * D));
        al = W'($urandom); ar = W'($urandom);
        wait_pos(100);
        strobe(al, ar, 1'b1);
        collect("half_rate", bits, lr);
        chk("half_rate_frame", bits, padw(al, ar));
        half = 1'b0;

        // Random traffic with a random clock enable
        for (int i = 0; i < 3000; i++) begin
            clk_en       = ($urandom_range(3) != 0);
            sample_valid = ($urandom_range(149) == 0);
            clr_flags    = ($urandom_range(79) == 0);
            left         = W'($urandom);
            right        = W'($urandom);
            cyc();
        end
        sample_valid = 1'b0;
        clr_flags = 1'b0;
        clk_en = 1'b1;
        $display("random phase done at t=%0t", $time);

        // Asynchronous reset in the right slot
        wait_pos(150);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 32'({bclk, lrclk, sdata, sample_ready, overrun, underrun}), 32'h04);
        repeat (3) cyc();
        rst_n = 1'b1;
        repeat (20) tick();
        chk("idle_after_reset", 32'({bclk, lrclk, sdata, sample_ready}), 32'h1);
        al = W'($urandom); ar = W'($urandom);
        strobe(al, ar, 1'b0);
        collect("after_reset", bits, lr);
        chk("after_reset_frame", bits, padw(al, ar));
        chk("after_reset_lrclk", lr, 32'h0001FFFE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
